// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor sequencer: feeds two parallel operands LSB-first
// through a single carry flip-flop and reassembles the serial sum.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             bit_a,
  output logic             bit_b,
  output logic             bit_q,
  output logic             state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  fsm_t             fsm;
  fsm_t             fsm_nxt;
  logic [WIDTH-1:0] sha;
  logic [WIDTH-1:0] shb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             prev_carry;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (start) fsm_nxt = SHIFT;
      SHIFT:   if (last)  fsm_nxt = DONE;
      DONE:    fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    bit_a = 1'b0;
    bit_b = 1'b0;
    bit_q = 1'b0;
    case (fsm)
      SHIFT: begin
        busy  = 1'b1;
        bit_a = sha[0];
        bit_b = shb[0];
        bit_q = sha[0] ^ shb[0] ^ state;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: carry cell, operand/result shifters, and the held result.
  always_ff @(posedge clock) begin
    if (reset) begin
      sha        <= '0;
      shb        <= '0;
      res        <= '0;
      cnt        <= '0;
      state      <= 1'b0;
      prev_carry <= 1'b0;
      sum        <= '0;
      carry_out  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            sha   <= op_a;
            shb   <= sub ? ~op_b : op_b;
            state <= sub;  // subtract is A + ~B + 1: carry-in supplies the +1
            cnt   <= '0;
            res   <= '0;
          end
        end
        SHIFT: begin
          state <= (bit_a & bit_b) | (bit_a & state) | (bit_b & state);
          sha   <= sha >> 1;
          shb   <= shb >> 1;
          res   <= {bit_q, res[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (last) prev_carry <= state;
        end
        DONE: begin
          sum       <= res;
          carry_out <= state;
          overflow  <= state ^ prev_carry;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8) with
// hand-computed sums, flags, latency and serial traces.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             sub   = 1'b0;
  logic [WIDTH-1:0] op_a  = '0;
  logic [WIDTH-1:0] op_b  = '0;
  logic             busy, done, carry_out, overflow;
  logic             bit_a, bit_b, bit_q, state;
  logic [WIDTH-1:0] sum;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(WIDTH), .CW(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .bit_a     (bit_a),
    .bit_b     (bit_b),
    .bit_q     (bit_q),
    .state     (state)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one operation from IDLE and watches it until the result is held.
  // Cycle k=1 is the first cycle after the accepting edge.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s, input logic [WIDTH-1:0] exp_sum,
                       input logic exp_c, input logic exp_v,
                       output logic [WIDTH-1:0] q_tr, output logic [WIDTH-1:0] s_tr);
    int busy_n = 0;
    int done_n = 0;
    int done_k = 0;
    q_tr = '0;
    s_tr = '0;
    @(negedge clock);
    start = 1'b1; op_a = a; op_b = b; sub = s;
    @(negedge clock);
    start = 1'b0; op_a = ~a; op_b = ~b; sub = ~s;
    for (int k = 1; k <= 12; k++) begin
      if (busy) begin
        busy_n++;
        if (k <= WIDTH) begin
          q_tr[k-1] = bit_q;
          s_tr[k-1] = state;
        end
      end
      if (done) begin
        done_n++;
        if (done_k == 0) done_k = k;
      end
      @(negedge clock);
    end
    check({tag, " busy_cycles"}, busy_n, WIDTH);
    check({tag, " done_cycle"}, done_k, WIDTH + 1);
    check({tag, " done_count"}, done_n, 1);
    check({tag, " sum"}, sum, exp_sum);
    check({tag, " carry_out"}, carry_out, exp_c);
    check({tag, " overflow"}, overflow, exp_v);
  endtask

  initial begin
    logic [WIDTH-1:0] q_tr, s_tr;
    int done_n;
    int done_ks[$];

    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst sum", sum, 0);
    check("rst carry_out", carry_out, 0);
    check("rst overflow", overflow, 0);
    check("rst state", state, 0);
    check("rst serial bits", {bit_a, bit_b, bit_q}, 0);

    do_op("add_basic", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, q_tr, s_tr);
    check("idle serial bits", {bit_a, bit_b, bit_q}, 0);

    do_op("add_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, q_tr, s_tr);
    check("add_wrap q_trace", q_tr, 8'h00);
    check("add_wrap state_trace", s_tr, 8'hFE);
    check("add_wrap state_held", state, 1);

    do_op("add_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, q_tr, s_tr);
    do_op("sub_10_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0, q_tr, s_tr);
    do_op("sub_01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0, q_tr, s_tr);

    // Start while busy: second pulse at busy cycle 3 must be dropped.
    @(negedge clock);
    start = 1'b1; op_a = 8'h11; op_b = 8'h22; sub = 1'b0;
    done_n = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      if (k == 3) begin
        start = 1'b1; op_a = 8'hF0; op_b = 8'h0F;
      end else begin
        start = 1'b0;
      end
      if (done) done_n++;
    end
    check("busy_start done_count", done_n, 1);
    check("busy_start sum", sum, 8'h33);
    check("busy_start idle", busy, 0);

    // Reset in SHIFT cycle 4 aborts the operation.
    @(negedge clock);
    start = 1'b1; op_a = 8'h55; op_b = 8'h22; sub = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_rst busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst busy", busy, 0);
    check("mid_rst sum", sum, 8'h00);
    check("mid_rst state", state, 0);
    done_n = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) done_n++;
      @(negedge clock);
    end
    check("mid_rst no_done", done_n, 0);
    do_op("after_rst", 8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0, q_tr, s_tr);

    // Back-to-back: start held high, one request per WIDTH+2 cycles.
    @(negedge clock);
    start = 1'b1; op_a = 8'h01; op_b = 8'h01; sub = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clock);
      if (done) done_ks.push_back(k);
      if (k == 10 || k == 20 || k == 30) check($sformatf("b2b sum k=%0d", k), sum, 8'h02);
    end
    start = 1'b0;
    check("b2b done_count", done_ks.size(), 3);
    if (done_ks.size() >= 3) begin
      check("b2b done1", done_ks[0], 9);
      check("b2b gap12", done_ks[1] - done_ks[0], WIDTH + 2);
      check("b2b gap23", done_ks[2] - done_ks[1], WIDTH + 2);
    end
    repeat (12) @(negedge clock);
    check("b2b final idle", busy, 0);
    check("b2b final sum", sum, 8'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer for the bit-serial carry datapath: a single carry flip-flop (`state`) with sum bit `q = a ^ b ^ state`.
- Accepts two WIDTH-bit operands with a start pulse and feeds them LSB-first into the carry cell, one bit per clock.
- Collects the serial `q` stream into a parallel result and reports carry, overflow and done.
- Sits between a parallel-register host and the serial adder. The carry cell is contained inside this block.

Parameters:
- WIDTH, 8, operand/result width in bits (2..32).
- CW, 6, bit-counter width; must satisfy 2^CW > WIDTH.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = add, 1 = subtract (op_a - op_b); sampled with start
- op_a  input  WIDTH  operand A; sampled with start
- op_b  input  WIDTH  operand B; sampled with start
- busy  output  1  high in SHIFT
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  result; held from done until the next accepted start
- carry_out  output  1  final carry (sub: 1 = no borrow)
- overflow  output  1  signed overflow of the result
- bit_a  output  1  serial A bit presented to the carry cell this cycle
- bit_b  output  1  serial B bit presented (after sub inversion)
- bit_q  output  1  serial sum bit this cycle
- state  output  1  current carry flip-flop value

Behaviour:
- One clock, named clock; reset synchronous and active-high, named reset.
- Reset (any state, including mid-operation) sets the following and aborts any operation in progress:
  - FSM to IDLE.
  - sum, carry_out, overflow, done, busy, state, bit counter all to 0.
  - Operand shift registers to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Latch sha <= op_a.
  - Latch shb <= sub ? ~op_b : op_b.
  - Carry <= sub.
  - Counter <= 0; result shift register <= 0.
  - Go to SHIFT.
- IDLE, start=0: stay. sum, carry_out and overflow are held.
- SHIFT, each cycle:
  - bit_a = sha[0], bit_b = shb[0], bit_q = bit_a ^ bit_b ^ state.
  - state <= (bit_a & bit_b) | (bit_a & state) | (bit_b & state).
  - sha and shb shift right by 1.
  - Result register shifts right with bit_q entering at MSB.
  - Counter increments.
- SHIFT, when counter == WIDTH-1:
  - Also record prev_carry <= state, which is the carry into the MSB.
  - Go to DONE.
- DONE, single cycle:
  - done=1; sum <= result register; carry_out <= state.
  - overflow <= state ^ prev_carry.
  - Go to IDLE.
  - sum, carry_out and overflow become visible the cycle after done rises, then stay stable.
- Latency: start sampled at edge N means:
  - busy is high for cycles N+1..N+WIDTH.
  - done is high in cycle N+WIDTH+1.
  - A new start is accepted no earlier than edge N+WIDTH+2 (the first IDLE cycle).
- start while busy or in DONE: ignored, with no queueing. op_a, op_b and sub may change freely after acceptance.
- Outside SHIFT: bit_a, bit_b and bit_q are 0. state holds its last value until the next start reloads it.
- Arithmetic is modulo 2^WIDTH.
  - Sub computes op_a + ~op_b + 1.
  - carry_out=1 means op_a >= op_b, unsigned.
- start and reset in the same cycle: reset wins.

Test Plan (WIDTH=8):
- Add, basic: reset 2 cycles, then start with op_a=0x35, op_b=0x4A, sub=0 → busy for 8 cycles, done in cycle 9, sum=0x7F, carry_out=0, overflow=0.
- Add, wrap-around: op_a=0xFF, op_b=0x01, sub=0 → sum=0x00, carry_out=1, overflow=0. Serial bit_q trace LSB-first is 0,0,0,0,0,0,0,0; state is 1 from the second SHIFT cycle onward.
- Signed overflow and subtract:
  - 0x7F+0x01 → sum=0x80, carry_out=0, overflow=1.
  - sub with 0x10-0x01 → sum=0x0F, carry_out=1.
  - sub with 0x01-0x02 → sum=0xFF, carry_out=0.
- Start while busy: start (0x11+0x22); pulse start with 0xF0+0x0F at busy cycle 3 → second request ignored, sum=0x33, exactly one done pulse.
- Reset mid-operation: assert reset in SHIFT cycle 4 → next cycle busy=0, sum=0x00, state=0, no done pulse. A following start (0x02+0x03) gives sum=0x05.
- Back-to-back: hold start=1 continuously with 0x01+0x01 → requests are accepted every WIDTH+2 cycles, done pulses 10 cycles apart, each sum=0x02.
